// File: rtl/fir_seq_ctrl_if.sv
// Control bus between the FIR sequencing FSM and the datapath blocks it steers
// (UART, byte-to-coefficient converter, coefficient bank, FIFO, FIR core, LEDs).
interface fir_seq_ctrl_if #(
  parameter int NUM_COEF = 16
);
  localparam int CNT_W = $clog2(NUM_COEF);

  // requests and status flowing into the controller
  logic             en_uart_i;
  logic             send_i;
  logic             coef_valid_i;
  logic             full_i;
  logic             empty_i;

  // enables and status flowing out of the controller
  logic             en_recepcion_o;
  logic             en_uart_o;
  logic             wr_o;
  logic             rd_o;
  logic             en_fir_o;
  logic             full_o;
  logic             load_done_o;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] coef_cnt_o;

  // controller side
  modport master (
    input  en_uart_i, send_i, coef_valid_i, full_i, empty_i,
    output en_recepcion_o, en_uart_o, wr_o, rd_o, en_fir_o, full_o,
           load_done_o, state_o, coef_cnt_o
  );

  // datapath / environment side
  modport slave (
    output en_uart_i, send_i, coef_valid_i, full_i, empty_i,
    input  en_recepcion_o, en_uart_o, wr_o, rd_o, en_fir_o, full_o,
           load_done_o, state_o, coef_cnt_o
  );
endinterface

// File: rtl/fir_seq_ctrl.sv
// FIR sequencing controller: loads NUM_COEF coefficients over the UART, runs
// the filter into a FIFO until it fills, streams the FIFO back to the PC and
// then either restarts filtering or parks in HOLD.
module fir_seq_ctrl #(
  parameter int NUM_COEF     = 16,
  parameter int AUTO_RESTART = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  fir_seq_ctrl_if.master       bus
);

  localparam int CNT_W = $clog2(NUM_COEF);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_COEF - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_FILTER = 3'd2,
    S_FULL   = 3'd3,
    S_SEND   = 3'd4,
    S_HOLD   = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic w_last;
  logic w_load_done;
  logic w_wr;
  logic w_rd;

  logic w_en_rec;
  logic w_en_uart;
  logic w_en_fir;
  logic w_full_led;

  assign w_last = (r_cnt == LAST_IDX);

  // state and coefficient counter registers; reset wins over everything
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // next-state, counter update and the input-qualified strobes (load_done, wr, rd)
  always_comb begin
    w_next      = r_state;
    w_cnt_nxt   = r_cnt;
    w_load_done = 1'b0;
    w_wr        = 1'b0;
    w_rd        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.en_uart_i) begin
          w_next    = S_LOAD;
          w_cnt_nxt = '0;
        end
      end
      S_LOAD: begin
        // en_uart_i / send_i deliberately not looked at here
        if (bus.coef_valid_i) begin
          if (w_last) begin
            w_load_done = 1'b1;
            w_cnt_nxt   = '0;
            w_next      = S_FILTER;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      S_FILTER: begin
        // write gated by full_i in the same cycle so a full FIFO is never written
        w_wr = !bus.full_i;
        if (bus.full_i) w_next = S_FULL;
      end
      S_FULL: begin
        if (bus.send_i) w_next = S_SEND;
      end
      S_SEND: begin
        // read gated by empty_i so an empty FIFO is never read
        w_rd = !bus.empty_i;
        if (bus.empty_i) w_next = (AUTO_RESTART != 0) ? S_FILTER : S_HOLD;
      end
      S_HOLD: begin
        // reload has priority over restart when both arrive together
        if (bus.en_uart_i) begin
          w_next    = S_LOAD;
          w_cnt_nxt = '0;
        end else if (bus.send_i) begin
          w_next = S_FILTER;
        end
      end
      default: begin
        // unused codes 6/7 recover to IDLE
        w_next    = S_IDLE;
        w_cnt_nxt = '0;
      end
    endcase
  end

  // Moore enables decoded purely from the registered state
  always_comb begin
    w_en_rec   = 1'b0;
    w_en_uart  = 1'b0;
    w_en_fir   = 1'b0;
    w_full_led = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_en_rec  = 1'b1;
        w_en_uart = 1'b1;
      end
      S_FILTER: w_en_fir   = 1'b1;
      S_FULL:   w_full_led = 1'b1;
      S_SEND:   w_en_uart  = 1'b1;
      default: ;
    endcase
  end

  assign bus.en_recepcion_o = w_en_rec;
  assign bus.en_uart_o      = w_en_uart;
  assign bus.en_fir_o       = w_en_fir;
  assign bus.full_o         = w_full_led;
  assign bus.state_o        = r_state;
  assign bus.coef_cnt_o     = r_cnt;

  // input-driven strobes are masked during reset so inputs have no effect then
  assign bus.load_done_o    = w_load_done & ~rst_i;
  assign bus.wr_o           = w_wr & ~rst_i;
  assign bus.rd_o           = w_rd & ~rst_i;

endmodule

// File: doc/fir_seq_ctrl.md
FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_COEF, default 16, number of FIR coefficients to load (legal 2..256).
REQ-002 SHALL have parameter AUTO_RESTART, default 0; 1 means filtering resumes automatically once the FIFO has drained.
REQ-003 SHALL derive localparam CNT_W = clog2(NUM_COEF); it is not user-settable.
REQ-004 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 en_uart_i  in  1  single-cycle, debounced request to load coefficients over the UART.
REQ-007 send_i  in  1  single-cycle, debounced request to transmit the FIFO contents to the PC.
REQ-008 coef_valid_i  in  1  one-cycle strobe per assembled coefficient from the byte-to-coefficient converter.
REQ-009 full_i  in  1  FIFO full flag.
REQ-010 empty_i  in  1  FIFO empty flag.
REQ-011 en_recepcion_o  out  1  enables coefficient capture in the converter and the coefficient bank.
REQ-012 en_uart_o  out  1  enables the UART, for receive during load and for transmit during send.
REQ-013 wr_o  out  1  FIFO write enable.
REQ-014 rd_o  out  1  FIFO read enable.
REQ-015 en_fir_o  out  1  FIR filter enable.
REQ-016 full_o  out  1  LED: FIFO full, waiting for send_i.
REQ-017 load_done_o  out  1  one-cycle pulse when the last coefficient has been accepted.
REQ-018 state_o  out  3  current state code, for debug.
REQ-019 coef_cnt_o  out  CNT_W  coefficients accepted so far in the current load.

Function
REQ-020 SHALL implement the states IDLE=0, LOAD=1, FILTER=2, FULL=3, SEND=4, HOLD=5; codes 6 and 7 SHALL return to IDLE on the next cycle.
REQ-021 Outputs en_recepcion_o, en_uart_o, en_fir_o, full_o and state_o SHALL be Moore outputs decoded from the registered state.
REQ-022 IDLE: all outputs 0; en_uart_i -> LOAD, with coef_cnt cleared to 0.
REQ-023 LOAD: en_recepcion_o=1 and en_uart_o=1; each coef_valid_i increments coef_cnt by 1.
REQ-024 LOAD exit: coef_valid_i while coef_cnt==NUM_COEF-1 SHALL assert load_done_o for 1 cycle, clear coef_cnt to 0 and enter FILTER; exactly NUM_COEF strobes are consumed, with no wrap beyond NUM_COEF-1.
REQ-025 LOAD: en_uart_i and send_i SHALL be ignored.
REQ-026 FILTER: en_fir_o=1; wr_o = !full_i, combinational so the FIFO can never be written while full; full_i=1 -> FULL.
REQ-027 FULL: full_o=1; wr_o, rd_o and en_fir_o are 0; send_i -> SEND.
REQ-028 SEND: en_uart_o=1; rd_o = !empty_i, combinational so the FIFO is never read while empty.
REQ-029 SEND exit: empty_i=1 -> FILTER if AUTO_RESTART=1, otherwise -> HOLD.
REQ-030 If SEND is entered with empty_i already 1, rd_o SHALL stay 0 and the block SHALL leave SEND on the next cycle.
REQ-031 HOLD: all outputs 0; send_i -> FILTER (restart with the existing coefficients); en_uart_i -> LOAD (reload coefficients).
REQ-032 If en_uart_i and send_i are asserted together in HOLD, SHALL go to LOAD.
REQ-033 In FILTER, full_i=1 SHALL force wr_o=0 in that same cycle, before the transition to FULL.
REQ-034 wr_o and rd_o SHALL never be 1 in the same cycle.

Reset
REQ-035 When rst_i=1 at a rising edge, the state SHALL go to IDLE and coef_cnt to 0, in any state, including mid-LOAD and mid-SEND.
REQ-036 After reset all outputs SHALL be 0; load_done_o SHALL NOT pulse.
REQ-037 While rst_i=1, all inputs SHALL be ignored; the first edge with rst_i=0 evaluates IDLE transitions normally.

Verification
REQ-038 Reset, then en_uart_i pulse, then 16 coef_valid_i strobes -> load_done_o pulses exactly once on the 16th strobe; the next state is FILTER with en_fir_o=1 and wr_o=1.
REQ-039 NUM_COEF=4: 3 strobes, then rst_i, then en_uart_i, then 4 strobes -> coef_cnt_o restarts at 0 and load_done_o pulses on the 4th strobe only.
REQ-040 FILTER, raise full_i -> wr_o=0 in the same cycle; next cycle full_o=1 and en_fir_o=0; send_i -> rd_o=1 and en_uart_o=1 while empty_i=0.
REQ-041 SEND, drop to empty_i=1 -> rd_o=0 immediately; AUTO_RESTART=0 gives HOLD (state_o=5); AUTO_RESTART=1 gives FILTER (state_o=2).
REQ-042 HOLD, pulse en_uart_i and send_i together -> state_o=1 and en_recepcion_o=1.
REQ-043 Across all tests, a checker SHALL flag any cycle with wr_o&rd_o, wr_o&full_i, or rd_o&empty_i -> zero violations.
